// File: rtl/score_loader_pkg.sv
// Shared definitions for the score loader: default widths, bank geometry and FSM state encoding.
package score_loader_pkg;

    // Default width of one square score.
    localparam int unsigned SCORE_W = 6;
    // Square index width (0..63).
    localparam int unsigned POS_W   = 6;
    // Squares per bank.
    localparam int unsigned N_SQ    = 64;
    // Fill counter width, wide enough to hold N_SQ itself.
    localparam int unsigned CNT_W   = 7;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPresent
    } state_e;

endpackage

// File: rtl/score_loader.sv
// Score loader: collects one score per square into a bank, then presents the complete bank
// to a downstream max-select tree until the consumer acknowledges it.
// Optional build macro SCORE_LOADER_TIMEOUT_EN adds a LOAD-state watchdog that ends the round
// after TIMEOUT_CYC cycles and sets the sticky timeout flag.
module score_loader #(
    parameter int unsigned SCORE_W     = score_loader_pkg::SCORE_W,
    parameter int unsigned N_SQ        = score_loader_pkg::N_SQ,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [SCORE_W-1:0]                         in_score,
    input  logic [score_loader_pkg::POS_W-1:0]         in_pos,
    output logic [N_SQ*SCORE_W-1:0]                    bank_scores,
    output logic [N_SQ*score_loader_pkg::POS_W-1:0]    bank_pos,
    output logic                                       bank_valid,
    input  logic                                       bank_ack,
    output logic                                       dup_err,
    output logic                                       timeout,
    output logic [score_loader_pkg::CNT_W-1:0]         fill_cnt
);
    import score_loader_pkg::*;

    // Fill count value at which the next fresh beat completes the bank.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SQ - 1);

    state_e                 state_q;
    logic [N_SQ-1:0]        mask_q;
    logic [SCORE_W-1:0]     scores_q [N_SQ];
    logic [CNT_W-1:0]       fill_q;
    logic                   dup_q;
    logic                   ready_q;
    logic                   valid_q;

    logic                   pos_ok;
    logic                   fire;
    logic                   fresh;
    logic                   complete;
    logic                   wdog_hit;

    // Positions beyond the bank (only possible when N_SQ < 64) are accepted and dropped.
    assign pos_ok   = (32'(in_pos) < N_SQ);
    // A start in LOAD restarts the round, so a beat in that same cycle does not transfer.
    assign fire     = ready_q && in_valid && !start && pos_ok;
    assign fresh    = fire && !mask_q[in_pos];
    assign complete = fresh && (fill_q == LAST_CNT);

    // Round control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mask_q  <= '0;
            fill_q  <= '0;
            dup_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        mask_q  <= '0;
                        fill_q  <= '0;
                        dup_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (start) begin
                        mask_q  <= '0;
                        fill_q  <= '0;
                        dup_q   <= 1'b0;
                    end else begin
                        if (fire) begin
                            if (mask_q[in_pos]) begin
                                dup_q <= 1'b1;
                            end else begin
                                mask_q[in_pos] <= 1'b1;
                                fill_q         <= fill_q + 1'b1;
                            end
                        end
                        if (complete || wdog_hit) begin
                            state_q <= StPresent;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                StPresent: begin
                    if (bank_ack) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Score storage; no reset needed since unfilled entries are masked at the output.
    always_ff @(posedge clk) begin
        if (fresh) begin
            scores_q[in_pos] <= in_score;
        end
    end

`ifdef SCORE_LOADER_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wdog_q;
    logic            timeout_q;

    // Last permitted LOAD cycle reached without the bank completing.
    assign wdog_hit = (state_q == StLoad) && !start && !complete &&
                      (wdog_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog counts LOAD cycles from round start; timeout flag is sticky until next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (start && (state_q != StPresent)) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == StLoad) begin
            wdog_q <= wdog_q + 1'b1;
            if (wdog_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Bank outputs: scores masked by fill state, positions are constant indices.
    for (genvar i = 0; i < int'(N_SQ); i++) begin : g_bank
        assign bank_scores[SCORE_W*i +: SCORE_W] = mask_q[i] ? scores_q[i] : '0;
        assign bank_pos[POS_W*i +: POS_W]        = POS_W'(i);
    end

    assign in_ready   = ready_q;
    assign bank_valid = valid_q;
    assign dup_err    = dup_q;
    assign fill_cnt   = fill_q;

endmodule

// File: tb/tb_score_loader.sv
// Self-checking bench for score_loader: table-driven handshake vectors plus directed
// sequences for full fills, duplicates, acknowledge timing, async reset and the watchdog.
module tb_score_loader;

    localparam int SW = 6;
    localparam int NS = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             bank_ack = 1'b0;
    logic [SW-1:0]    in_score = '0;
    logic [5:0]       in_pos = '0;

    logic             in_ready;
    logic [NS*SW-1:0] bank_scores;
    logic [NS*6-1:0]  bank_pos;
    logic             bank_valid;
    logic             dup_err;
    logic             timeout;
    logic [6:0]       fill_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    score_loader #(
        .SCORE_W     (SW),
        .N_SQ        (NS),
        .TIMEOUT_CYC (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_score    (in_score),
        .in_pos      (in_pos),
        .bank_scores (bank_scores),
        .bank_pos    (bank_pos),
        .bank_valid  (bank_valid),
        .bank_ack    (bank_ack),
        .dup_err     (dup_err),
        .timeout     (timeout),
        .fill_cnt    (fill_cnt)
    );

`ifdef SCORE_LOADER_TIMEOUT_EN
    logic             wd_in_ready;
    logic [NS*SW-1:0] wd_bank_scores;
    logic [NS*6-1:0]  wd_bank_pos;
    logic             wd_bank_valid;
    logic             wd_dup_err;
    logic             wd_timeout;
    logic [6:0]       wd_fill_cnt;

    score_loader #(
        .SCORE_W     (SW),
        .N_SQ        (NS),
        .TIMEOUT_CYC (20)
    ) dut_wd (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (wd_in_ready),
        .in_score    (in_score),
        .in_pos      (in_pos),
        .bank_scores (wd_bank_scores),
        .bank_pos    (wd_bank_pos),
        .bank_valid  (wd_bank_valid),
        .bank_ack    (bank_ack),
        .dup_err     (wd_dup_err),
        .timeout     (wd_timeout),
        .fill_cnt    (wd_fill_cnt)
    );
`endif

    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic       st;
        logic       vld;
        logic [5:0] pos;
        logic [5:0] sc;
        logic       ack;
        logic       e_rdy;
        logic [6:0] e_fill;
        logic       e_dup;
        logic       e_bv;
        int         idx;
        logic [5:0] e_sc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] entry(input int i);
        return bank_scores[SW*i +: SW];
    endfunction

    function automatic int count_zero(input logic [NS*SW-1:0] b);
        int n = 0;
        for (int i = 0; i < NS; i++) begin
            if (b[SW*i +: SW] == '0) n++;
        end
        return n;
    endfunction

    // Entries not matching i%50, except skip_idx which must equal skip_val.
    function automatic int bank_errs(input int skip_idx, input logic [SW-1:0] skip_val);
        int n = 0;
        logic [SW-1:0] e;
        for (int i = 0; i < NS; i++) begin
            e = (i == skip_idx) ? skip_val : SW'(i % 50);
            if (entry(i) !== e) n++;
        end
        return n;
    endfunction

    // Apply inputs away from the active edge, then sample 1 time unit after it.
    task automatic drive(input logic s, input logic v, input logic [5:0] p,
                         input logic [SW-1:0] sc, input logic a);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_pos   = p;
        in_score = sc;
        bank_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        bank_ack = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pos_errs;
        int first;

        // {start, valid, pos, score, ack, exp ready, exp fill, exp dup, exp bank_valid, idx, exp entry}
        vecs[0] = '{1'b0, 1'b0, 6'd0, 6'd0,  1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 0, 6'd0};
        vecs[1] = '{1'b1, 1'b1, 6'd3, 6'd7,  1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 3, 6'd0};
        vecs[2] = '{1'b0, 1'b1, 6'd3, 6'd7,  1'b0, 1'b1, 7'd1, 1'b0, 1'b0, 3, 6'd7};
        vecs[3] = '{1'b0, 1'b1, 6'd4, 6'd9,  1'b1, 1'b1, 7'd2, 1'b0, 1'b0, 4, 6'd9};
        vecs[4] = '{1'b0, 1'b1, 6'd3, 6'd20, 1'b0, 1'b1, 7'd2, 1'b1, 1'b0, 3, 6'd7};
        vecs[5] = '{1'b0, 1'b0, 6'd0, 6'd0,  1'b0, 1'b1, 7'd2, 1'b1, 1'b0, 4, 6'd9};
        vecs[6] = '{1'b1, 1'b1, 6'd5, 6'd1,  1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 3, 6'd0};
        vecs[7] = '{1'b0, 1'b1, 6'd5, 6'd11, 1'b0, 1'b1, 7'd1, 1'b0, 1'b0, 5, 6'd11};

        do_reset();

        // Reset state
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_valid", 64'(bank_valid), 64'(0));
        check("rst_fill", 64'(fill_cnt), 64'(0));
        check("rst_dup", 64'(dup_err), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_zero_entries", 64'(count_zero(bank_scores)), 64'(NS));
        pos_errs = 0;
        for (int i = 0; i < NS; i++) begin
            if (bank_pos[6*i +: 6] !== 6'(i)) pos_errs++;
        end
        check("bank_pos_const", 64'(pos_errs), 64'(0));

        // Table: idle, start+valid in IDLE, beats, ack in LOAD, duplicate, restart with dropped beat
        for (int k = 0; k < 8; k++) begin
            drive(vecs[k].st, vecs[k].vld, vecs[k].pos, vecs[k].sc, vecs[k].ack);
            check($sformatf("v%0d_ready", k), 64'(in_ready), 64'(vecs[k].e_rdy));
            check($sformatf("v%0d_fill", k), 64'(fill_cnt), 64'(vecs[k].e_fill));
            check($sformatf("v%0d_dup", k), 64'(dup_err), 64'(vecs[k].e_dup));
            check($sformatf("v%0d_bank_valid", k), 64'(bank_valid), 64'(vecs[k].e_bv));
            check($sformatf("v%0d_entry%0d", k, vecs[k].idx), 64'(entry(vecs[k].idx)),
                  64'(vecs[k].e_sc));
        end

        // Forward fill, back-to-back beats
        do_reset();
        drive(1'b1, 1'b0, 6'd0, '0, 1'b0);
        for (int i = 0; i < NS; i++) begin
            drive(1'b0, 1'b1, 6'(i), SW'(i % 50), 1'b0);
            if (i == NS - 2) begin
                check("fwd_not_valid_at_63", 64'(bank_valid), 64'(0));
                check("fwd_fill_63", 64'(fill_cnt), 64'(63));
            end
        end
        check("fwd_bank_valid", 64'(bank_valid), 64'(1));
        check("fwd_ready_low", 64'(in_ready), 64'(0));
        check("fwd_fill_64", 64'(fill_cnt), 64'(64));
        check("fwd_entry63", 64'(entry(63)), 64'(13));
        check("fwd_bank_errs", 64'(bank_errs(-1, '0)), 64'(0));
        // start and beats ignored in PRESENT
        drive(1'b1, 1'b1, 6'd0, 6'd33, 1'b0);
        check("pres_start_ign_valid", 64'(bank_valid), 64'(1));
        check("pres_start_ign_fill", 64'(fill_cnt), 64'(64));
        check("pres_hold_entry0", 64'(entry(0)), 64'(0));
        check("pres_hold_errs", 64'(bank_errs(-1, '0)), 64'(0));
        // ack at N gives bank_valid low at N+1
        drive(1'b0, 1'b0, 6'd0, '0, 1'b1);
        check("ack_valid_low", 64'(bank_valid), 64'(0));
        check("ack_ready_low", 64'(in_ready), 64'(0));
        drive(1'b0, 1'b1, 6'd1, 6'd1, 1'b0);
        idle();
        check("post_ack_ready_low", 64'(in_ready), 64'(0));
        check("post_ack_valid_low", 64'(bank_valid), 64'(0));

        // Reverse fill with gaps in in_valid
        do_reset();
        drive(1'b1, 1'b0, 6'd0, '0, 1'b0);
        for (int k = 0; k < NS; k++) begin
            if (k % 3 == 1) idle();
            if (k == NS - 1) check("rev_not_valid_before_last", 64'(bank_valid), 64'(0));
            drive(1'b0, 1'b1, 6'(NS - 1 - k), SW'((NS - 1 - k) % 50), 1'b0);
        end
        check("rev_bank_valid", 64'(bank_valid), 64'(1));
        check("rev_fill", 64'(fill_cnt), 64'(64));
        check("rev_bank_errs", 64'(bank_errs(-1, '0)), 64'(0));
        drive(1'b0, 1'b0, 6'd0, '0, 1'b1);
        check("rev_ack", 64'(bank_valid), 64'(0));

        // Duplicate square 5, completion still needs all distinct squares
        do_reset();
        drive(1'b1, 1'b0, 6'd0, '0, 1'b0);
        drive(1'b0, 1'b1, 6'd5, 6'd10, 1'b0);
        drive(1'b0, 1'b1, 6'd5, 6'd40, 1'b0);
        check("dup_entry5", 64'(entry(5)), 64'(10));
        check("dup_flag", 64'(dup_err), 64'(1));
        check("dup_fill", 64'(fill_cnt), 64'(1));
        for (int i = 0; i < NS; i++) begin
            if (i != 5) begin
                if (i == NS - 1) begin
                    check("dup_not_valid_at_63", 64'(bank_valid), 64'(0));
                    check("dup_fill_63", 64'(fill_cnt), 64'(63));
                end
                drive(1'b0, 1'b1, 6'(i), SW'(i % 50), 1'b0);
            end
        end
        check("dup_bank_valid", 64'(bank_valid), 64'(1));
        check("dup_fill_64", 64'(fill_cnt), 64'(64));
        check("dup_sticky", 64'(dup_err), 64'(1));
        check("dup_bank_errs", 64'(bank_errs(5, 6'd10)), 64'(0));

        // Async reset mid-LOAD after 30 beats
        do_reset();
        drive(1'b1, 1'b0, 6'd0, '0, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 6'(i), SW'(i + 1), 1'b0);
        drive(1'b0, 1'b1, 6'd2, 6'd9, 1'b0);
        check("mid_fill30", 64'(fill_cnt), 64'(30));
        check("mid_dup", 64'(dup_err), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(in_ready), 64'(0));
        check("arst_fill", 64'(fill_cnt), 64'(0));
        check("arst_dup", 64'(dup_err), 64'(0));
        check("arst_valid", 64'(bank_valid), 64'(0));
        check("arst_zero_entries", 64'(count_zero(bank_scores)), 64'(NS));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 6'd7, 6'd7, 1'b0);
        check("arst_needs_start_ready", 64'(in_ready), 64'(0));
        check("arst_needs_start_fill", 64'(fill_cnt), 64'(0));

        // Watchdog: 10 beats only
        do_reset();
        drive(1'b1, 1'b0, 6'd0, '0, 1'b0);
        first = -1;
        for (int k = 0; k < 40; k++) begin
            if (k < 10) drive(1'b0, 1'b1, 6'(k), SW'(k + 1), 1'b0);
            else        idle();
`ifdef SCORE_LOADER_TIMEOUT_EN
            if (first < 0 && wd_bank_valid) first = k + 1;
`endif
        end
`ifdef SCORE_LOADER_TIMEOUT_EN
        check("wd_latency", 64'(first), 64'(20));
        check("wd_timeout", 64'(wd_timeout), 64'(1));
        check("wd_fill", 64'(wd_fill_cnt), 64'(10));
        check("wd_ready", 64'(wd_in_ready), 64'(0));
        check("wd_zero_entries", 64'(count_zero(wd_bank_scores)), 64'(54));
        drive(1'b1, 1'b0, 6'd0, '0, 1'b1);
        check("wd_ack", 64'(wd_bank_valid), 64'(0));
        check("wd_timeout_sticky", 64'(wd_timeout), 64'(1));
`else
        check("nowd_first", 64'(first), 64'(-1));
        check("nowd_valid", 64'(bank_valid), 64'(0));
        check("nowd_ready", 64'(in_ready), 64'(1));
        check("nowd_timeout", 64'(timeout), 64'(0));
        check("nowd_fill", 64'(fill_cnt), 64'(10));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_loader.md
SCORE_LOADER -- requirements
Module: score_loader

Interface
REQ-001 SHALL have parameter SCORE_W, default 6: width of one square score.
REQ-002 SHALL have parameter N_SQ, default 64: squares per bank; position width is 6.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256: LOAD-state watchdog limit, used only when SCORE_LOADER_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: begins a new collection round.
REQ-007 SHALL have port in_valid, input, 1: a score beat is offered.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a beat this cycle.
REQ-009 SHALL have port in_score, input, SCORE_W: score of the square.
REQ-010 SHALL have port in_pos, input, 6: square index 0..63.
REQ-011 SHALL have port bank_scores, output, N_SQ*SCORE_W: entry i at bits [SCORE_W*i +: SCORE_W].
REQ-012 SHALL have port bank_pos, output, N_SQ*6: entry i holds constant i; this is the position input of the downstream max-select tree.
REQ-013 SHALL have port bank_valid, output, 1: bank is complete and stable.
REQ-014 SHALL have port bank_ack, input, 1: the consumer has taken the winner.
REQ-015 SHALL have port dup_err, output, 1: sticky flag, a square was written twice this round.
REQ-016 SHALL have port timeout, output, 1: sticky flag, the round ended by watchdog.
REQ-017 SHALL have port fill_cnt, output, 7: number of distinct squares filled, 0..64.

Function
REQ-018 SHALL implement the FSM IDLE -> LOAD -> PRESENT -> IDLE.
REQ-019 IDLE: in_ready=0; start -> LOAD next cycle; on that transition, clear fill mask, fill_cnt, dup_err and timeout.
REQ-020 LOAD: in_ready=1; a beat transfers when in_valid && in_ready; it stores in_score at index in_pos, sets mask[in_pos] and increments fill_cnt.
REQ-021 A beat to an already-set mask bit SHALL NOT overwrite the entry or count, and SHALL set dup_err.
REQ-022 The transfer making fill_cnt 64 SHALL move the FSM to PRESENT; bank_valid=1 from the next cycle.
REQ-023 start asserted in LOAD SHALL restart the round (same clears as REQ-019), and any beat in that cycle is dropped.
REQ-024 PRESENT: in_ready=0; bank_scores and bank_pos are held stable; bank_ack -> IDLE, with bank_valid=0 the next cycle; start is ignored.
REQ-025 bank_scores entry i SHALL read 0 whenever mask[i]=0 (masked at output).
REQ-026 In IDLE, start and in_valid in the same cycle SHALL accept no beat.
REQ-027 bank_ack outside PRESENT SHALL be ignored.

Reset
REQ-028 rst_n low SHALL force, asynchronously: FSM=IDLE, mask=0, fill_cnt=0, in_ready=0, bank_valid=0, dup_err=0, timeout=0. Score registers need no reset because they are masked.
REQ-029 Reset mid-LOAD or mid-PRESENT SHALL discard the round; no partial bank_valid is produced.

Configuration
REQ-030 With SCORE_LOADER_TIMEOUT_EN defined:
- a cycle counter starts at 0 on entry to LOAD;
- at TIMEOUT_CYC cycles in LOAD without completion, the FSM enters PRESENT and sets timeout;
- unfilled entries read 0 per REQ-025.
REQ-031 Without SCORE_LOADER_TIMEOUT_EN: no counter is built, timeout is tied to 0, and LOAD waits indefinitely.

Structure
REQ-032 The shared chess package SHALL hold SCORE_W, POS_W=6, N_SQ=64, and the FSM state enum.
REQ-033 The block SHALL be a single module with no sub-module; the optional watchdog counter is inline.

Verification
REQ-034 Reset, then start, then 64 beats with pos=i, score=i%50 back-to-back -> bank_valid on the cycle after the 64th beat; entry 63 = 13; fill_cnt=64.
REQ-035 Reverse-order beats (pos 63..0) with gaps in in_valid -> identical bank contents; bank_valid only after the final beat.
REQ-036 pos 5 written with 10, then again with 40 -> entry 5 stays 10, dup_err=1, fill_cnt not incremented; completion still requires all 64 distinct squares.
REQ-037 PRESENT with bank_ack at cycle N -> bank_valid=0 at N+1; in_ready stays 0 until a new start.
REQ-038 TIMEOUT_EN with TIMEOUT_CYC=20, 10 beats only -> PRESENT after 20 LOAD cycles; timeout=1; 54 entries read 0. Without the macro -> remains in LOAD.
REQ-039 rst_n pulled low mid-LOAD after 30 beats -> all outputs at reset values immediately; a new start is needed.
